// File: rtl/fp_apu_pkg.sv
// Shared types and constants for the FP APU dispatch block.
package fp_apu_pkg;

  localparam logic [7:0] APU_FLAGS_HI = 8'b1000_0000;

  typedef struct packed {
    logic [2:0][31:0] operands;
    logic [5:0]       op;
    logic [2:0]       rnd;
    logic [4:0]       rd;
  } fp_req_t;

  typedef enum logic {
    IDLE,
    REQ
  } fsm_state_t;

endpackage

// File: rtl/fp_apu_dispatch_if.sv
// Issue, APU and writeback signals of the FP dispatch block.
interface fp_apu_dispatch_if;

  logic             issue_valid_i;
  logic             issue_ready_o;
  logic [2:0][31:0] issue_operands_i;
  logic [5:0]       issue_op_i;
  logic [2:0]       issue_rnd_i;
  logic [4:0]       issue_rd_i;

  logic             apu_req_o;
  logic             apu_gnt_i;
  logic [2:0][31:0] apu_operands_o;
  logic [5:0]       apu_op_o;
  logic [10:0]      apu_flags_o;
  logic             apu_rvalid_i;
  logic [31:0]      apu_rdata_i;
  logic [4:0]       apu_rflags_i;

  logic             wb_valid_o;
  logic [4:0]       wb_rd_o;
  logic [31:0]      wb_data_o;
  logic [4:0]       wb_fflags_o;

  logic [4:0]       fflags_o;
  logic             fflags_clr_i;
  logic             err_o;

  // The dispatch block is the slave; the core plus fp_wrapper side is the master.
  modport slave (
    input  issue_valid_i, issue_operands_i, issue_op_i, issue_rnd_i, issue_rd_i,
    input  apu_gnt_i, apu_rvalid_i, apu_rdata_i, apu_rflags_i, fflags_clr_i,
    output issue_ready_o, apu_req_o, apu_operands_o, apu_op_o, apu_flags_o,
    output wb_valid_o, wb_rd_o, wb_data_o, wb_fflags_o, fflags_o, err_o
  );

  modport master (
    output issue_valid_i, issue_operands_i, issue_op_i, issue_rnd_i, issue_rd_i,
    output apu_gnt_i, apu_rvalid_i, apu_rdata_i, apu_rflags_i, fflags_clr_i,
    input  issue_ready_o, apu_req_o, apu_operands_o, apu_op_o, apu_flags_o,
    input  wb_valid_o, wb_rd_o, wb_data_o, wb_fflags_o, fflags_o, err_o
  );

endinterface

// File: rtl/fp_sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head read.
module fp_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage is left unreset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fp_apu_dispatch.sv
// Buffers FP ops from the core, hands them to the APU under an outstanding limit,
// and returns in-order results to the register file with accrued exception flags.
module fp_apu_dispatch
  import fp_apu_pkg::*;
#(
  parameter int unsigned IQ_DEPTH  = 2,
  parameter int unsigned MAX_OUTST = 2
) (
  input logic              clk_i,
  input logic              rst_ni,
  fp_apu_dispatch_if.slave bus
);

  localparam int unsigned IQ_CNT_W  = $clog2(IQ_DEPTH + 1);
  localparam int unsigned TAG_CNT_W = $clog2(MAX_OUTST + 1);

  fp_req_t              iq_wdata;
  fp_req_t              iq_head;
  logic                 iq_push;
  logic                 iq_pop;
  logic                 iq_full;
  logic                 iq_empty;
  logic [IQ_CNT_W-1:0]  iq_count;
  logic [IQ_CNT_W-1:0]  iq_count_next;

  logic [4:0]           tag_head;
  logic                 tag_push;
  logic                 tag_pop;
  logic                 tag_full;
  logic                 tag_empty;
  logic [TAG_CNT_W-1:0] tag_count;
  logic [TAG_CNT_W-1:0] tag_count_next;

  fsm_state_t           state_q;
  fsm_state_t           state_d;
  logic                 req;
  logic                 grant;
  logic                 rsp_accept;
  logic                 eligible_next;

  logic                 wb_valid_q;
  logic [4:0]           wb_rd_q;
  logic [31:0]          wb_data_q;
  logic [4:0]           wb_fflags_q;
  logic [4:0]           fflags_q;
  logic                 err_q;

  assign iq_wdata = '{operands: bus.issue_operands_i,
                      op:       bus.issue_op_i,
                      rnd:      bus.issue_rnd_i,
                      rd:       bus.issue_rd_i};

  assign bus.issue_ready_o = !iq_full;
  assign iq_push           = bus.issue_valid_i && !iq_full;

  fp_sync_fifo #(
    .WIDTH ($bits(fp_req_t)),
    .DEPTH (IQ_DEPTH)
  ) u_issue_q (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (iq_push),
    .wdata (iq_wdata),
    .pop   (iq_pop),
    .rdata (iq_head),
    .full  (iq_full),
    .empty (iq_empty),
    .count (iq_count)
  );

  // The tag FIFO occupancy doubles as the outstanding-request counter.
  fp_sync_fifo #(
    .WIDTH (5),
    .DEPTH (MAX_OUTST)
  ) u_tag_q (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (tag_push),
    .wdata (iq_head.rd),
    .pop   (tag_pop),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  assign req        = (state_q == REQ);
  assign grant      = req && bus.apu_gnt_i && !iq_empty && !tag_full;
  assign iq_pop     = grant;
  assign tag_push   = grant;
  assign rsp_accept = bus.apu_rvalid_i && !tag_empty;
  assign tag_pop    = rsp_accept;

  assign bus.apu_req_o      = req;
  assign bus.apu_operands_o = iq_head.operands;
  assign bus.apu_op_o       = iq_head.op;
  assign bus.apu_flags_o    = {APU_FLAGS_HI, iq_head.rnd};

  // Eligibility looks at next-cycle occupancy so a fresh issue requests one cycle later.
  always_comb begin
    iq_count_next  = iq_count + IQ_CNT_W'(iq_push) - IQ_CNT_W'(iq_pop);
    tag_count_next = tag_count + TAG_CNT_W'(tag_push) - TAG_CNT_W'(tag_pop);
    eligible_next  = (iq_count_next != '0) && (tag_count_next < TAG_CNT_W'(MAX_OUTST));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (eligible_next) state_d = REQ;
      REQ:     if (grant && !eligible_next) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clear takes priority over accrual, then the same-cycle response flags are ORed in.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_fflags_q <= '0;
      fflags_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      wb_valid_q <= rsp_accept;
      if (rsp_accept) begin
        wb_rd_q     <= tag_head;
        wb_data_q   <= bus.apu_rdata_i;
        wb_fflags_q <= bus.apu_rflags_i;
      end
      if (bus.apu_rvalid_i && tag_empty) err_q <= 1'b1;
      if (bus.fflags_clr_i)  fflags_q <= rsp_accept ? bus.apu_rflags_i : 5'b0;
      else if (rsp_accept)   fflags_q <= fflags_q | bus.apu_rflags_i;
    end
  end

  assign bus.wb_valid_o  = wb_valid_q;
  assign bus.wb_rd_o     = wb_rd_q;
  assign bus.wb_data_o   = wb_data_q;
  assign bus.wb_fflags_o = wb_fflags_q;
  assign bus.fflags_o    = fflags_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_fp_apu_dispatch.sv
// Scoreboard bench for fp_apu_dispatch: issued ops, grants and responses are
// tracked in queues and every writeback is matched against the expected entry.
module tb_fp_apu_dispatch;
  import fp_apu_pkg::*;

  localparam int IQ_DEPTH  = 2;
  localparam int MAX_OUTST = 2;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  flags;
  } wb_exp_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  fp_apu_dispatch_if bus ();

  fp_apu_dispatch #(
    .IQ_DEPTH (IQ_DEPTH),
    .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus.slave)
  );

  fp_req_t    iss_q[$];
  logic [4:0] tag_q[$];
  wb_exp_t    wb_q[$];
  logic [4:0] exp_fflags = '0;
  logic       exp_err    = 1'b0;
  logic       armed      = 1'b0;
  int         checks     = 0;
  int         failures   = 0;
  int         grant_cnt  = 0;
  int         wb_cnt     = 0;

  // Outputs seen at a falling edge reflect the previous rising edge, so compare
  // first and then fold this cycle's inputs into the model.
  always @(negedge clk_i) begin
    wb_exp_t    e;
    fp_req_t    h;
    logic       acc;
    if (armed) begin
      checks++;
      if (bus.wb_valid_o !== (wb_q.size() != 0)) begin
        failures++;
        $display("[TB] FAIL wb_valid got=%b exp=%b", bus.wb_valid_o, (wb_q.size() != 0));
      end
      if (bus.wb_valid_o === 1'b1 && wb_q.size() != 0) begin
        e = wb_q.pop_front();
        wb_cnt++;
        checks++;
        if (bus.wb_rd_o !== e.rd || bus.wb_data_o !== e.data || bus.wb_fflags_o !== e.flags) begin
          failures++;
          $display("[TB] FAIL wb_fields got=%0d/%h/%b exp=%0d/%h/%b", bus.wb_rd_o, bus.wb_data_o,
                   bus.wb_fflags_o, e.rd, e.data, e.flags);
        end
      end
      checks++;
      if (bus.fflags_o !== exp_fflags) begin
        failures++;
        $display("[TB] FAIL fflags got=%b exp=%b", bus.fflags_o, exp_fflags);
      end
      checks++;
      if (bus.err_o !== exp_err) begin
        failures++;
        $display("[TB] FAIL err got=%b exp=%b", bus.err_o, exp_err);
      end
      checks++;
      if (bus.issue_ready_o !== (iss_q.size() < IQ_DEPTH)) begin
        failures++;
        $display("[TB] FAIL issue_ready got=%b exp=%b", bus.issue_ready_o, (iss_q.size() < IQ_DEPTH));
      end

      if (!rst_ni) begin
        iss_q.delete();
        tag_q.delete();
        wb_q.delete();
        exp_fflags = '0;
        exp_err    = 1'b0;
      end else begin
        acc = bus.apu_rvalid_i && (tag_q.size() != 0);
        if (bus.apu_rvalid_i === 1'b1) begin
          if (acc) wb_q.push_back('{rd: tag_q.pop_front(), data: bus.apu_rdata_i, flags: bus.apu_rflags_i});
          else     exp_err = 1'b1;
        end
        if (bus.fflags_clr_i === 1'b1) exp_fflags = acc ? bus.apu_rflags_i : 5'b0;
        else if (acc)                  exp_fflags = exp_fflags | bus.apu_rflags_i;

        if (bus.apu_req_o === 1'b1 && bus.apu_gnt_i === 1'b1) begin
          grant_cnt++;
          checks++;
          if (iss_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL grant_without_op got=1 exp=0");
          end else begin
            h = iss_q.pop_front();
            tag_q.push_back(h.rd);
            if (bus.apu_operands_o !== h.operands || bus.apu_op_o !== h.op ||
                bus.apu_flags_o !== {8'h80, h.rnd}) begin
              failures++;
              $display("[TB] FAIL grant_fields got=%h/%b/%b exp=%h/%b/%b", bus.apu_operands_o,
                       bus.apu_op_o, bus.apu_flags_o, h.operands, h.op, {8'h80, h.rnd});
            end
          end
        end
        if (bus.issue_valid_i === 1'b1 && bus.issue_ready_o === 1'b1)
          iss_q.push_back('{operands: bus.issue_operands_i, op: bus.issue_op_i,
                            rnd: bus.issue_rnd_i, rd: bus.issue_rd_i});
      end
    end
  end

  function automatic fp_req_t make_op(input logic [4:0] rd, input logic [31:0] a,
                                      input logic [31:0] b, input logic [2:0] rnd);
    fp_req_t r;
    r.operands[0] = a;
    r.operands[1] = b;
    r.operands[2] = 32'h0;
    r.op          = 6'b000010;
    r.rnd         = rnd;
    r.rd          = rd;
    return r;
  endfunction

  task automatic clear_inputs();
    bus.issue_valid_i    = 1'b0;
    bus.issue_operands_i = '0;
    bus.issue_op_i       = '0;
    bus.issue_rnd_i      = '0;
    bus.issue_rd_i       = '0;
    bus.apu_gnt_i        = 1'b0;
    bus.apu_rvalid_i     = 1'b0;
    bus.apu_rdata_i      = '0;
    bus.apu_rflags_i     = '0;
    bus.fflags_clr_i     = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    clear_inputs();
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic drive_op(input fp_req_t r);
    bus.issue_operands_i = r.operands;
    bus.issue_op_i       = r.op;
    bus.issue_rnd_i      = r.rnd;
    bus.issue_rd_i       = r.rd;
    bus.issue_valid_i    = 1'b1;
  endtask

  // Holds the op until a falling edge shows ready, then lets the handshake edge pass.
  task automatic issue_op(input fp_req_t r);
    int   n  = 0;
    logic ok = 1'b0;
    drive_op(r);
    do begin
      @(negedge clk_i);
      ok = (bus.issue_ready_o === 1'b1);
      n++;
    end while (!ok && n < 50);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL issue_timeout got=%b exp=1", bus.issue_ready_o);
    end
    @(posedge clk_i); #1;
    bus.issue_valid_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic [4:0] flags, input logic clr);
    bus.apu_rvalid_i = 1'b1;
    bus.apu_rdata_i  = data;
    bus.apu_rflags_i = flags;
    bus.fflags_clr_i = clr;
    @(posedge clk_i); #1;
    bus.apu_rvalid_i = 1'b0;
    bus.fflags_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_i);
    checks++;
    if (bus.apu_req_o !== 1'b0 || bus.wb_valid_o !== 1'b0 || bus.wb_rd_o !== 5'd0 ||
        bus.wb_data_o !== 32'd0 || bus.wb_fflags_o !== 5'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%b/%b/%0d/%h/%b exp=0/0/0/0/0", bus.apu_req_o,
               bus.wb_valid_o, bus.wb_rd_o, bus.wb_data_o, bus.wb_fflags_o);
    end
    checks++;
    if (bus.issue_ready_o !== 1'b1 || bus.fflags_o !== 5'd0 || bus.err_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_status got=%b/%b/%b exp=1/00000/0", bus.issue_ready_o,
               bus.fflags_o, bus.err_o);
    end
  endtask

  task automatic test_single_op();
    int g0, w0;
    do_reset();
    g0 = grant_cnt;
    w0 = wb_cnt;
    issue_op(make_op(5'd5, 32'h4020_0000, 32'h4020_0000, 3'd0));
    bus.apu_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (bus.apu_req_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_req_latency got=%b exp=1", bus.apu_req_o);
    end
    @(posedge clk_i); #1;
    bus.apu_gnt_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (bus.apu_req_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_req_drop got=%b exp=0", bus.apu_req_o);
    end
    @(posedge clk_i); #1;
    respond(32'h40C8_0000, 5'b00000, 1'b0);
    @(negedge clk_i);
    checks++;
    if (bus.wb_valid_o !== 1'b1 || bus.wb_rd_o !== 5'd5 || bus.wb_data_o !== 32'h40C8_0000) begin
      failures++;
      $display("[TB] FAIL single_wb got=%b/%0d/%h exp=1/5/40c80000", bus.wb_valid_o,
               bus.wb_rd_o, bus.wb_data_o);
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checks++;
    if (bus.wb_valid_o !== 1'b0 || grant_cnt - g0 != 1 || wb_cnt - w0 != 1) begin
      failures++;
      $display("[TB] FAIL single_counts got=%b/%0d/%0d exp=0/1/1", bus.wb_valid_o,
               grant_cnt - g0, wb_cnt - w0);
    end
  endtask

  task automatic test_backpressure();
    fp_req_t a, b, c;
    int      n;
    int      g0, w0;
    logic    ok;
    do_reset();
    g0 = grant_cnt;
    w0 = wb_cnt;
    a = make_op(5'd1, 32'h3F80_0000, 32'h4000_0000, 3'd1);
    b = make_op(5'd2, 32'h4040_0000, 32'h4080_0000, 3'd2);
    c = make_op(5'd3, 32'h40A0_0000, 32'h40C0_0000, 3'd3);
    issue_op(a);
    issue_op(b);
    drive_op(c);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if (bus.issue_ready_o !== 1'b0 || bus.apu_req_o !== 1'b1 ||
          bus.apu_operands_o !== a.operands || bus.apu_op_o !== a.op ||
          bus.apu_flags_o !== {8'h80, a.rnd}) begin
        failures++;
        $display("[TB] FAIL backpressure_hold got=%b/%b/%h/%b exp=0/1/%h/%b", bus.issue_ready_o,
                 bus.apu_req_o, bus.apu_operands_o, bus.apu_flags_o, a.operands, {8'h80, a.rnd});
      end
    end
    @(posedge clk_i); #1;
    bus.apu_gnt_i = 1'b1;
    n  = 0;
    ok = 1'b0;
    do begin
      @(negedge clk_i);
      ok = (bus.issue_ready_o === 1'b1);
      n++;
    end while (!ok && n < 20);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL backpressure_third_issue got=%b exp=1", bus.issue_ready_o);
    end
    @(posedge clk_i); #1;
    bus.issue_valid_i = 1'b0;
    wait_cycles(2);
    respond(32'h1111_0001, 5'b00000, 1'b0);
    wait_cycles(3);
    respond(32'h2222_0002, 5'b00000, 1'b0);
    wait_cycles(3);
    respond(32'h3333_0003, 5'b00000, 1'b0);
    wait_cycles(3);
    bus.apu_gnt_i = 1'b0;
    checks++;
    if (grant_cnt - g0 != 3 || wb_cnt - w0 != 3) begin
      failures++;
      $display("[TB] FAIL backpressure_counts got=%0d/%0d exp=3/3", grant_cnt - g0, wb_cnt - w0);
    end
  endtask

  task automatic test_outstanding();
    int g0, w0;
    do_reset();
    g0 = grant_cnt;
    w0 = wb_cnt;
    bus.apu_gnt_i = 1'b1;
    issue_op(make_op(5'd7, 32'h0000_0007, 32'h0000_0070, 3'd0));
    issue_op(make_op(5'd8, 32'h0000_0008, 32'h0000_0080, 3'd4));
    issue_op(make_op(5'd9, 32'h0000_0009, 32'h0000_0090, 3'd2));
    wait_cycles(4);
    checks++;
    if (grant_cnt - g0 != 2) begin
      failures++;
      $display("[TB] FAIL outstanding_limit got=%0d exp=2", grant_cnt - g0);
    end
    @(negedge clk_i);
    checks++;
    if (bus.apu_req_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL outstanding_req_drop got=%b exp=0", bus.apu_req_o);
    end
    @(posedge clk_i); #1;
    respond(32'hAAAA_0007, 5'b00000, 1'b0);
    wait_cycles(3);
    checks++;
    if (grant_cnt - g0 != 3) begin
      failures++;
      $display("[TB] FAIL outstanding_resume got=%0d exp=3", grant_cnt - g0);
    end
    respond(32'hAAAA_0008, 5'b00000, 1'b0);
    respond(32'hAAAA_0009, 5'b00000, 1'b0);
    wait_cycles(2);
    bus.apu_gnt_i = 1'b0;
    checks++;
    if (wb_cnt - w0 != 3) begin
      failures++;
      $display("[TB] FAIL outstanding_wb got=%0d exp=3", wb_cnt - w0);
    end
  endtask

  task automatic test_flags();
    do_reset();
    bus.apu_gnt_i = 1'b1;
    issue_op(make_op(5'd10, 32'h1, 32'h2, 3'd0));
    issue_op(make_op(5'd11, 32'h3, 32'h4, 3'd0));
    wait_cycles(3);
    respond(32'h0000_00A0, 5'b00001, 1'b0);
    respond(32'h0000_00A1, 5'b10000, 1'b0);
    @(negedge clk_i);
    checks++;
    if (bus.fflags_o !== 5'b10001) begin
      failures++;
      $display("[TB] FAIL flags_accrue got=%b exp=10001", bus.fflags_o);
    end
    @(posedge clk_i); #1;
    issue_op(make_op(5'd12, 32'h5, 32'h6, 3'd0));
    wait_cycles(3);
    respond(32'h0000_00A2, 5'b00100, 1'b1);
    @(negedge clk_i);
    checks++;
    if (bus.fflags_o !== 5'b00100 || bus.wb_fflags_o !== 5'b00100) begin
      failures++;
      $display("[TB] FAIL flags_clear got=%b/%b exp=00100/00100", bus.fflags_o, bus.wb_fflags_o);
    end
    @(posedge clk_i); #1;
    bus.apu_gnt_i = 1'b0;
  endtask

  task automatic test_spurious();
    do_reset();
    respond(32'hDEAD_BEEF, 5'b11111, 1'b0);
    @(negedge clk_i);
    checks++;
    if (bus.err_o !== 1'b1 || bus.wb_valid_o !== 1'b0 || bus.fflags_o !== 5'b0) begin
      failures++;
      $display("[TB] FAIL spurious_rsp got=%b/%b/%b exp=1/0/00000", bus.err_o, bus.wb_valid_o,
               bus.fflags_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.apu_gnt_i = 1'b1;
    issue_op(make_op(5'd20, 32'h20, 32'h21, 3'd1));
    @(posedge clk_i); #1;
    bus.apu_gnt_i = 1'b0;
    issue_op(make_op(5'd21, 32'h22, 32'h23, 3'd1));
    issue_op(make_op(5'd22, 32'h24, 32'h25, 3'd1));
    @(negedge clk_i);
    checks++;
    if (bus.issue_ready_o !== 1'b0 || bus.apu_req_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_full got=%b/%b exp=0/1", bus.issue_ready_o, bus.apu_req_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checks++;
    if (bus.apu_req_o !== 1'b0 || bus.wb_valid_o !== 1'b0 || bus.fflags_o !== 5'b0 ||
        bus.err_o !== 1'b0 || bus.issue_ready_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got=%b/%b/%b/%b/%b exp=0/0/00000/0/1", bus.apu_req_o,
               bus.wb_valid_o, bus.fflags_o, bus.err_o, bus.issue_ready_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    respond(32'h5555_0020, 5'b00010, 1'b0);
    @(negedge clk_i);
    checks++;
    if (bus.err_o !== 1'b1 || bus.wb_valid_o !== 1'b0 || bus.issue_ready_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_stale_rsp got=%b/%b/%b exp=1/0/1", bus.err_o, bus.wb_valid_o,
               bus.issue_ready_o);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    armed = 1'b1;
    test_reset();
    test_single_op();
    test_backpressure();
    test_outstanding();
    test_flags();
    test_spurious();
    test_reset_mid();
    wait_cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_apu_dispatch.md
FP_APU_DISPATCH -- requirements
Module: fp_apu_dispatch

Interface
REQ-001 Parameter: IQ_DEPTH, default 2, issue-queue entries (power of two, >=2).
REQ-002 Parameter: MAX_OUTST, default 2, max APU requests granted but not yet answered.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  reset, synchronous, active-low.
REQ-005 issue_valid_i  in  1  core offers an FP op.
REQ-006 issue_ready_o  out  1  block accepts the op.
REQ-007 issue_operands_i  in  3x32  operands a,b,c.
REQ-008 issue_op_i  in  6  {1'b0, op_mod, fp_op[3:0]}.
REQ-009 issue_rnd_i  in  3  rounding mode.
REQ-010 issue_rd_i  in  5  destination register tag.
REQ-011 apu_req_o  out  1  request to fp_wrapper.
REQ-012 apu_gnt_i  in  1  grant from fp_wrapper.
REQ-013 apu_operands_o  out  3x32, apu_op_o  out  6: queue head fields.
REQ-014 apu_flags_o  out  11  {2'b10, 3'b000, 3'b000, rnd}.
REQ-015 apu_rvalid_i  in  1, apu_rdata_i  in  32, apu_rflags_i  in  5: APU response.
REQ-016 wb_valid_o  out  1, wb_rd_o  out  5, wb_data_o  out  32, wb_fflags_o  out  5: writeback to core.
REQ-017 fflags_o  out  5  sticky accrued exception flags; fflags_clr_i  in  1  clears them.
REQ-018 err_o  out  1  sticky: response received with no outstanding tag.

Function
REQ-019 Issue queue: FIFO of {operands, op, rnd, rd}; push on issue_valid_i & issue_ready_o; issue_ready_o = !full (no same-cycle bypass when full, even if head pops).
REQ-020 FSM states IDLE, REQ; IDLE->REQ when queue non-empty and outstanding < MAX_OUTST; REQ->IDLE on apu_gnt_i when no further head eligible, else stays REQ.
REQ-021 apu_req_o = 1 only in REQ; operands/op/flags driven from queue head, held stable until apu_gnt_i.
REQ-022 On apu_req_o & apu_gnt_i: pop head, push its rd into tag FIFO (depth MAX_OUTST); earliest apu_req_o is the cycle after the issue handshake.
REQ-023 Outstanding counter: +1 on grant, -1 on accepted response, both same cycle -> unchanged; never exceeds MAX_OUTST.
REQ-024 Responses are in order: apu_rvalid_i pops tag FIFO; next cycle wb_valid_o=1 for exactly one cycle with wb_rd_o=popped tag, wb_data_o=apu_rdata_i, wb_fflags_o=apu_rflags_i.
REQ-025 apu_rvalid_i with empty tag FIFO: no writeback, err_o set, counter unchanged.
REQ-026 fflags_o |= apu_rflags_i on each accepted response; fflags_clr_i same cycle -> fflags_o = apu_rflags_i (clear before OR).
REQ-027 Grant and response in the same cycle are both processed; response of an op granted this cycle is not possible (min APU latency 1).

Reset
REQ-028 On rst_ni=0 at clock edge: queues empty, FSM IDLE, counter 0, apu_req_o=0, wb_valid_o=0, wb_rd_o=0, wb_data_o=0, wb_fflags_o=0, fflags_o=0, err_o=0; issue_ready_o=1 the cycle after reset releases.
REQ-029 Reset mid-operation discards queued and outstanding ops; later responses for them set err_o.

Structure
REQ-030 Shared package fp_apu_pkg: fp_req_t struct {operands, op, rnd, rd}, APU_FLAGS_HI constant 8'b10000000, FSM state enum.
REQ-031 One sub-module fp_sync_fifo (parameterised width/depth, synchronous, full/empty), instanced for issue queue and tag FIFO.

Verification
REQ-032 Single op: operands 0x40200000, 0x40200000, 0, op 6'b000010, rnd 0, rd 5 -> one apu_req_o, after response wb_valid_o with wb_rd_o=5, wb_data_o=0x40C80000.
REQ-033 Back-pressure: apu_gnt_i low 5 cycles -> apu_req_o and head fields stable; 3rd issue sees issue_ready_o=0 with IQ_DEPTH=2.
REQ-034 Outstanding limit: 3 ops, no responses -> exactly 2 grants, apu_req_o drops; one response -> 3rd request issues.
REQ-035 Flags: responses with rflags 5'b00001 then 5'b10000 -> fflags_o=5'b10001; clr with rflags 5'b00100 same cycle -> 5'b00100.
REQ-036 Spurious apu_rvalid_i after reset -> err_o=1, wb_valid_o stays 0.
REQ-037 Reset asserted with 2 ops queued -> all outputs at reset values next cycle, issue_ready_o=1 after release.
